// File: rtl/pc_pkg.sv
// Shared types and default parameter values for the fetch-stage PC generator.
package pc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  localparam int unsigned PC_DEF_STEP      = 4;
  localparam logic [31:0] PC_DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_gen_if.sv
// Control/status bundle between the fetch controller (master) and pc_gen (slave).
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic            stall_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic [XLEN-1:0] pc_o;
  logic            pc_valid_o;
  logic            redirect_pending_o;
  logic            misalign_o;
  logic [XLEN-1:0] badaddr_o;

  modport master (
    output start_i, stall_i, redirect_valid_i, redirect_pc_i,
    input  pc_o, pc_valid_o, redirect_pending_o, misalign_o, badaddr_o
  );

  modport slave (
    input  start_i, stall_i, redirect_valid_i, redirect_pc_i,
    output pc_o, pc_valid_o, redirect_pending_o, misalign_o, badaddr_o
  );
endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry holding register for a redirect that arrives while fetch is stalled.
// A write overwrites any older entry; consume and clear both empty it.
module pc_redirect_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr,
  input  logic            consume,
  input  logic            clr,
  input  logic [XLEN-1:0] wr_data,
  output logic            valid,
  output logic [XLEN-1:0] data
);

  // Occupancy flag: emptied on consume/clear, set on write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid <= 1'b0;
    end else if (consume || clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
    end
  end

  // Payload register, overwritten by every write.
  // NOTE: the payload has no reset; it is only ever observed while valid is set.
  always_ff @(posedge clk_i) begin
    if (wr) begin
      data <= wr_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: sequential increment,
// live redirect, stall-buffered redirect and an IDLE/RUN fetch gate.
// Build option: define PC_MISALIGN_TRAP_EN to divert misaligned targets to
// TRAP_VEC (with misalign_o/badaddr_o reporting); otherwise misaligned
// targets are silently aligned down.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_DEF_RESET_VEC),
  parameter int unsigned     STEP      = PC_DEF_STEP,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PC_DEF_TRAP_VEC)
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  pc_gen_if.slave  bus
);

  // Low address bits that must be zero for an aligned target.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
  localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

  // Reject configurations that cannot work: STEP not a power of two, or a
  // trap vector that would itself be misaligned.
  if ((STEP == 0) || ((STEP & (STEP - 1)) != 0) ||
      ((TRAP_VEC & ALIGN_MASK) != '0)) begin : g_cfg_check
    $error("pc_gen: STEP must be a power of two and TRAP_VEC STEP-aligned");
  end

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q;
  logic            load_target;
  logic            pc_inc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] load_pc;
  logic            buf_wr, buf_consume, buf_clr;
  logic            buf_valid;
  logic [XLEN-1:0] buf_data;

  pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr      (buf_wr),
    .consume (buf_consume),
    .clr     (buf_clr),
    .wr_data (bus.redirect_pc_i),
    .valid   (buf_valid),
    .data    (buf_data)
  );

  // Next-state and next-PC source selection.
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path leaves it unassigned and infers a latch.
    state_d     = bus.start_i ? RUN : IDLE;
    load_target = 1'b0;
    pc_inc      = 1'b0;
    target      = bus.redirect_pc_i;
    buf_wr      = 1'b0;
    buf_consume = 1'b0;
    buf_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Boot-vector override; stall is irrelevant while idle.
        if (bus.redirect_valid_i) begin
          load_target = 1'b1;
          buf_clr     = 1'b1;
        end
      end
      RUN: begin
        if (bus.stall_i) begin
          buf_wr = bus.redirect_valid_i;
        end else if (bus.redirect_valid_i) begin
          // A live redirect wins even when fetch is being stopped.
          load_target = 1'b1;
          buf_clr     = 1'b1;
        end else if (bus.start_i && buf_valid) begin
          load_target = 1'b1;
          target      = buf_data;
          buf_consume = 1'b1;
        end else if (bus.start_i) begin
          pc_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic            target_misaligned;
  logic            misalign_q;
  logic [XLEN-1:0] badaddr_q;

  // Misaligned targets are diverted to the trap vector.
  always_comb begin
    target_misaligned = |(target & ALIGN_MASK);
    load_pc           = target_misaligned ? TRAP_VEC : target;
  end

  // One-cycle trap pulse together with the faulting address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misalign_q <= 1'b0;
      badaddr_q  <= '0;
    end else begin
      misalign_q <= load_target && target_misaligned;
      if (load_target && target_misaligned) begin
        badaddr_q <= target;
      end
    end
  end

  assign bus.misalign_o = misalign_q;
  assign bus.badaddr_o  = badaddr_q;
`else
  // Misaligned targets are aligned down; no trap reporting exists.
  always_comb begin
    load_pc = target & ~ALIGN_MASK;
  end

  assign bus.misalign_o = 1'b0;
  assign bus.badaddr_o  = '0;
`endif

  // Next-PC mux: loaded target, increment (wraps naturally), or hold.
  always_comb begin
    if (load_target) begin
      pc_d = load_pc;
    end else if (pc_inc) begin
      pc_d = pc_q + STEP_INC;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC, fetch state and registered valid flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= (state_d == RUN);
    end
  end

  assign bus.pc_o               = pc_q;
  assign bus.pc_valid_o         = pc_valid_q;
  assign bus.redirect_pending_o = buf_valid;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It replaces the plain load-on-enable PC register: it computes the next PC itself (sequential increment, redirect, buffered redirect) and gates fetch with a start/run state machine. A redirect that arrives during a stall is held until the stall ends. Misaligned targets can optionally be trapped.

## Interface
- `XLEN`, 32: PC width in bits.
- `RESET_VEC`, 32'h0000_0000: PC value after reset.
- `STEP`, 4: sequential increment in bytes; power of two, ≥1.
- `TRAP_VEC`, 32'h0000_0100: PC loaded on a misaligned redirect (only when `PC_MISALIGN_TRAP_EN` is defined).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: run enable; level-sensitive.
- `stall_i` in 1: hold the PC this cycle.
- `redirect_valid_i` in 1: branch, jump or exception redirect request.
- `redirect_pc_i` in XLEN: redirect target.
- `pc_o` out XLEN: current fetch PC.
- `pc_valid_o` out 1: `pc_o` is a valid fetch address (state RUN).
- `redirect_pending_o` out 1: the buffered redirect is occupied.
- `misalign_o` out 1: one-cycle pulse when a misaligned target is trapped.
- `badaddr_o` out XLEN: last trapped target.

## Operation
- **Reset values:** state IDLE; `pc_o`=`RESET_VEC`; `pc_valid_o`=0; pending buffer empty, so `redirect_pending_o`=0; `misalign_o`=0; `badaddr_o`=0.
- **IDLE state**
  - `start_i`=1 → RUN. `pc_o` is unchanged, so the first valid fetch address is the held PC.
  - `redirect_valid_i`=1 (sampled in IDLE) loads `redirect_pc_i` directly into `pc_o` (boot-vector override) and clears the pending buffer.
  - `stall_i` is ignored.
- **RUN state**
  - `start_i`=0 → IDLE. `pc_o` holds; the pending buffer is retained.
  - `stall_i`=1: `pc_o` holds. A redirect arriving this cycle is written into the pending buffer. A newer redirect overwrites an older buffered one.
  - `stall_i`=0, next-PC priority:
    1. live redirect: `redirect_pc_i`; the pending buffer is cleared.
    2. pending buffer: load the buffered PC; the buffer is cleared.
    3. otherwise `pc_o + STEP`, modulo 2^XLEN. `{XLEN{1'b1}} - STEP + 1` wraps to 0.
- **Alignment:** a target is misaligned when any of its low log2(`STEP`) bits is non-zero. The check applies to live and buffered targets at the moment they are loaded, in both IDLE and RUN.
- **State effect:** `start_i` deasserted in the same cycle as a non-stalled redirect → the redirect is still loaded and the state goes to IDLE.

## Timing
- Single-cycle latency: inputs sampled at edge N are visible on `pc_o` after edge N.
- `pc_valid_o` rises on the first edge that samples `start_i`=1. It falls on the edge that samples `start_i`=0.
- A redirect buffered during a stall takes effect on the first edge with `stall_i`=0. Total delay = stall length + 1 cycle.
- `redirect_pending_o` is set on the edge that buffers a redirect and cleared on the edge that consumes or discards it.
- `misalign_o` is high for exactly one cycle, aligned with `pc_o`=`TRAP_VEC`.
- Reset asserted mid-operation (including with a redirect pending) restores all reset values asynchronously. The buffered redirect is lost.

## Configuration
- **`PC_MISALIGN_TRAP_EN` defined:**
  - A misaligned target loads `TRAP_VEC` instead.
  - `badaddr_o` captures the raw target.
  - `misalign_o` pulses.
- **`PC_MISALIGN_TRAP_EN` undefined:**
  - The target's low log2(`STEP`) bits are forced to zero and the masked value is loaded.
  - `misalign_o` is tied 0 and `badaddr_o` is tied 0; the trap logic is not instantiated.

## Structure
- **Package `pc_pkg`:**
  - state enum `pc_state_e` {IDLE, RUN};
  - `PC_DEF_STEP`;
  - `PC_DEF_RESET_VEC`;
  - `PC_DEF_TRAP_VEC`.
- **Sub-module `pc_redirect_buf`:** one-entry holding register. It has write (overwrite), consume and clear inputs; a valid flag; and an XLEN data output. It uses the same clock and reset as `pc_gen`.
- The alignment check and next-PC mux stay in `pc_gen`.

## Test plan
- **Reset and start:** release reset, hold `start_i`=0 for 3 cycles, then set `start_i`=1 with no stall → `pc_o` stays 0x0 and `pc_valid_o`=0 while idle. After start, `pc_o` goes 0x0, 0x4, 0x8, 0xC on successive edges.
- **Redirect during stall:**
  - In RUN at `pc_o`=0x10, hold `stall_i`=1 for 3 cycles. Redirect 0x200 in cycle 1 and 0x300 in cycle 2.
  - → `pc_o` holds 0x10 and `redirect_pending_o`=1. After the stall, `pc_o`=0x300, then 0x304.
- **Simultaneous live and pending:** with 0x300 pending, drop the stall and redirect 0x400 in the same cycle → `pc_o`=0x400 and the pending buffer is cleared.
- **Wrap-around:** redirect to 0xFFFF_FFFC, no stall → next `pc_o`=0x0000_0000.
- **Misaligned target:** redirect 0x102.
  - Macro defined → `pc_o`=0x100 (`TRAP_VEC`), `misalign_o` high for 1 cycle, `badaddr_o`=0x102.
  - Macro undefined → `pc_o`=0x100 (masked), `misalign_o`=0.
- **Reset mid-operation:** assert `rst_ni`=0 asynchronously with 0x300 pending → immediately `pc_o`=0x0, `pc_valid_o`=0, `redirect_pending_o`=0. After reset release, `pc_o` stays 0x0 and `pc_valid_o`=0 until `start_i`=1 is sampled.
